// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that sequences one write at a time into a shared level-sensitive latch bank.
// Each write runs SETUP -> ENABLE -> HOLD so latch_d is stable around the whole latch_e pulse.
module latch_write_arbiter #(
  parameter int WIDTH        = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int EN_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] latch_d,
  output logic             latch_e,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

  // Counter holds (phase length - 1) and counts down to zero.
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] EN_LD    = 4'(EN_CYCLES - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       owner;
  logic       last;
  logic       win;

  // last=1 means requester 1 was served most recently, so requester 0 wins a tie.
  always_comb begin
    win = req1;
    if (req0 && req1) win = ~last;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      owner   <= 1'b0;
      last    <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      latch_d <= '0;
      latch_e <= 1'b0;
      busy    <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state   <= SETUP;
            cnt     <= SETUP_LD;
            owner   <= win;
            last    <= win;
            gnt0    <= ~win;
            gnt1    <= win;
            latch_d <= win ? data1 : data0;
            busy    <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            state   <= ENABLE;
            cnt     <= EN_LD;
            latch_e <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ENABLE: begin
          if (cnt == 4'd0) begin
            state   <= HOLD;
            cnt     <= HOLD_LD;
            latch_e <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done0 <= ~owner;
            done1 <= owner;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          latch_e <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/latch_write_arbiter.md
LATCH_WRITE_ARBITER -- requirements
Module: latch_write_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; all state changes occur on the rising edge of clk.
REQ-002 Parameter WIDTH, default 4, SHALL set the latch data width in bits.
REQ-003 Parameter SETUP_CYCLES, default 1, SHALL set the cycles latch_d is stable before latch_e rises; legal range 1-15.
REQ-004 Parameter EN_CYCLES, default 2, SHALL set the cycles latch_e stays high; legal range 1-15.
REQ-005 Parameter HOLD_CYCLES, default 1, SHALL set the cycles latch_d is stable after latch_e falls; legal range 1-15.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 req0, req1  input  1 each  level write request from requester 0 and requester 1.
REQ-009 data0, data1  input  WIDTH each  write data from each requester, sampled in the grant cycle.
REQ-010 gnt0, gnt1  output  1 each  one-cycle accept pulse.
REQ-011 done0, done1  output  1 each  one-cycle completion pulse.
REQ-012 latch_d  output  WIDTH  D input to the shared gate-level D latch bank.
REQ-013 latch_e  output  1  E (enable) input to the shared latch bank.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SETUP, ENABLE and HOLD. All outputs SHALL be registered.
REQ-016 IDLE->SETUP: on an edge in IDLE where req0 or req1 is high.
- The winner's gnt SHALL be high for the following cycle.
- The winner's data SHALL load into latch_d on that same edge.
REQ-017 SETUP->ENABLE after SETUP_CYCLES cycles; latch_e rises on that edge.
REQ-018 ENABLE->HOLD after EN_CYCLES cycles; latch_e falls on that edge.
REQ-019 HOLD->IDLE after HOLD_CYCLES cycles; the winner's done SHALL be high for the following cycle.
REQ-020 latch_e SHALL be high only in ENABLE and SHALL never glitch.
REQ-021 latch_d SHALL change only on the IDLE->SETUP edge. In IDLE it SHALL hold the last written value.
REQ-022 Arbitration SHALL be round-robin. When both requests are high in IDLE, the requester not served last wins. A single requester SHALL win regardless of the pointer. The pointer SHALL update only on a grant.
REQ-023 Requests SHALL be ignored outside IDLE; no queuing. A request withdrawn before it is granted SHALL produce no gnt and no done.
REQ-024 A req still high in the cycle done is high SHALL be treated as a new request. The earliest re-grant is the edge ending the done cycle, so IDLE lasts at least 1 cycle between transactions.
REQ-025 Transaction occupancy from the grant edge to the return to IDLE SHALL be SETUP_CYCLES + EN_CYCLES + HOLD_CYCLES cycles.
REQ-026 A single phase counter of 4 bits SHALL time all phases. It reloads on every state change and never wraps within a phase.
REQ-027 gnt0/gnt1 SHALL be mutually exclusive, as SHALL done0/done1. done SHALL go to the granted requester only.

Reset
REQ-028 While rst_n is low at an edge, the block SHALL set:
- state IDLE;
- latch_e, busy, gnt0, gnt1, done0, done1 all 0;
- latch_d 0;
- round-robin pointer = "requester 1 served last", so requester 0 wins the first tie.
REQ-029 Reset in any state, including mid-ENABLE, SHALL take effect on that edge. No done SHALL be issued for the aborted transaction. Requests sampled on the first edge with rst_n high SHALL be arbitrated normally.

Verification
All scenarios use default parameters; edge k is the grant edge.
REQ-030 req0=1, data0=4'hA, edge k in IDLE ->
- gnt0 high cycle k..k+1 and latch_d=4'hA from edge k;
- latch_e high from edge k+1 to k+3;
- done0 high cycle k+4..k+5;
- busy high from edge k to k+4.
REQ-031 After reset, req0 and req1 rise together with data0=4'h3, data1=4'hC, and are dropped after their gnt ->
- gnt0 first, latch_d=3;
- then gnt1 at edge k+5, latch_d=C;
- one latch_e pulse each.
REQ-032 req0 and req1 held high for 4 transactions -> grants alternate 0,1,0,1; each grant is exactly 5 cycles after the previous one.
REQ-033 rst_n low for one edge at k+2, during ENABLE ->
- latch_e, latch_d and busy are 0 after that edge;
- no done0 is issued;
- with req0 still high, re-grant occurs at edge k+3.
REQ-034 req1 asserted at edge k+1 during req0's transaction and dropped at k+3 -> no gnt1 and no done1; latch_d stays at data0.
REQ-035 With SETUP_CYCLES=EN_CYCLES=HOLD_CYCLES=1 and req0=1 ->
- latch_e is high for exactly 1 cycle, cycle k+1..k+2;
- done0 is high cycle k+3..k+4.
